// File: rtl/ucsbece154a_lsu.sv
// ucsbece154a_lsu: byte/half/word load-store unit; sub-word stores as read-modify-write.
// Define UCSBECE154A_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of coercing them.
module ucsbece154a_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);
  typedef enum logic [2:0] {IDLE, ACCESS, WRITE, RESP, FAULT} state_t;
  state_t state, state_n;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, merge_q, addr_c, ld, merge;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [4:0]  sh;
  logic        accept, byte_i, half_i, go_fault;
  assign accept = req_i && ready_o;
  assign byte_i = funct3_i[1:0] == 2'b00;
  assign half_i = funct3_i[1:0] == 2'b01;
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
  assign go_fault = half_i ? addr_i[0] : !byte_i && addr_i[1:0] != 2'b00;
  assign addr_c = addr_i;
  assign misaligned_o = state == FAULT;
`else
  assign go_fault = 1'b0;
  assign addr_c = {addr_i[31:2], addr_i[1] & (byte_i | half_i), addr_i[0] & byte_i};
  assign misaligned_o = 1'b0;
`endif
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = !accept ? IDLE : go_fault ? FAULT : ACCESS;
      ACCESS:  state_n = we_q && !f3_q[1] ? WRITE : RESP;
      WRITE:   state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  assign ready_o  = state == IDLE;
  assign done_o   = state == RESP || state == FAULT;
  assign mem_we_o = state == WRITE || (state == ACCESS && we_q && f3_q[1]);
  assign mem_a_o  = {addr_q[31:2], 2'b00};
  assign mem_wd_o = state == WRITE ? merge_q : wdata_q;
  // lane extraction and sign/zero extension for loads
  assign sh = {addr_q[1:0], 3'b000};
  assign lb = addr_q[1] ? (addr_q[0] ? mem_rd_i[31:24] : mem_rd_i[23:16])
                        : (addr_q[0] ? mem_rd_i[15:8] : mem_rd_i[7:0]);
  assign lh = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  assign ld = f3_q[1] ? mem_rd_i
            : f3_q[0] ? {{16{!f3_q[2] & lh[15]}}, lh}
            : {{24{!f3_q[2] & lb[7]}}, lb};
  assign merge = f3_q[0] ? (addr_q[1] ? {wdata_q[15:0], mem_rd_i[15:0]} : {mem_rd_i[31:16], wdata_q[15:0]})
               : (mem_rd_i & ~(32'hFF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      merge_q <= 32'b0;
      rdata_o <= 32'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= we_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_c;
        wdata_q <= wdata_i;
      end
      if (state == ACCESS && !we_q) rdata_o <= ld;
      if (state == ACCESS) merge_q <= merge;
    end
  end
endmodule

// File: tb/tb_ucsbece154a_lsu.sv
// tb_ucsbece154a_lsu: randomized bench against a byte-addressed reference memory model.
module tb_ucsbece154a_lsu;
  logic clk = 0, reset = 1, req = 0, we = 0;
  logic [2:0] f3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ready, done, mis, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] pm [64];
  logic [7:0] rb [256];
  logic [31:0] exp_rdata = 0;
  int checks = 0, errors = 0;
  typedef struct {logic w; logic [2:0] f; logic [31:0] a, d;} req_t;
  req_t q[$];

  ucsbece154a_lsu dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready), .done_o(done), .rdata_o(rdata), .misaligned_o(mis),
    .mem_we_o(mem_we), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = pm[mem_a[7:2]];
  always @(posedge clk) if (mem_we) pm[mem_a[7:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: byte-level memory, latency and write count from the access class
  task automatic model(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int wes, output logic m);
    int n, ea;
    logic [31:0] v;
    n = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
    ea = int'(a[7:0]);
    m = 1'b0;
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
    m = (ea % n) != 0;
`else
    ea = ea - ea % n;
`endif
    lat = 1;
    wes = 0;
    if (!m && w) begin
      for (int i = 0; i < n; i++) rb[ea + i] = d[8*i +: 8];
      lat = n == 4 ? 2 : 3;
      wes = 1;
    end else if (!m) begin
      v = 0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rb[ea + i];
      if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      exp_rdata = v;
      lat = 2;
    end
  endtask

  task automatic xact(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int lat, wes, el, ew;
    logic em, mis_seen;
    @(negedge clk);
    chk("ready_idle", 32'(ready), 1);
    req = 1; we = w; f3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'($urandom); we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0; wes = 0; mis_seen = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      chk("ready_busy", 32'(ready), 0);
      if (mem_we) begin
        wes++;
        chk("we_align", 32'(mem_a[1:0]), 0);
      end
      if (done) begin
        lat = i;
        mis_seen = mis;
      end
    end
    req = 0;
    model(w, f, a, d, el, ew, em);
    chk("latency", lat, el);
    chk("we_cycles", wes, ew);
    chk("misaligned", 32'(mis_seen), 32'(em));
    chk("rdata", rdata, exp_rdata);
  endtask

  task automatic mem_cmp();
    for (int i = 0; i < 64; i++) chk("mem", pm[i], {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]});
  endtask

  initial begin
    int el, ew, acc, dn;
    logic em;
    req_t r;
    for (int i = 0; i < 64; i++) pm[i] = 0;
    for (int i = 0; i < 256; i++) rb[i] = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_mis", 32'(mis), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_a", mem_a, 0);
    chk("rst_wd", mem_wd, 0);
    xact(1, 3'b010, 32'h10, 32'hDEADBEEF);
    xact(0, 3'b010, 32'h10, 32'h0);
    chk("lw", rdata, 32'hDEADBEEF);
    chk("sw_mem", pm[4], 32'hDEADBEEF);
    xact(1, 3'b000, 32'h12, 32'h55);
    chk("sb_mem", pm[4], 32'hDE55BEEF);
    xact(0, 3'b000, 32'h13, 0); chk("lb", rdata, 32'hFFFFFFDE);
    xact(0, 3'b100, 32'h13, 0); chk("lbu", rdata, 32'h000000DE);
    xact(0, 3'b001, 32'h10, 0); chk("lh", rdata, 32'hFFFFBEEF);
    xact(0, 3'b101, 32'h12, 0); chk("lhu", rdata, 32'h0000DE55);
    xact(0, 3'b010, 32'h11, 0);
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
    chk("lw_mis", rdata, 32'h0000DE55);
`else
    chk("lw_mis", rdata, 32'hDE55BEEF);
`endif
    // reset during the WRITE state of an SH
    @(negedge clk);
    req = 1; we = 1; f3 = 3'b001; addr = 32'h10; wdata = 32'h1234;
    @(posedge clk);
    #1 req = 0;
    repeat (2) @(negedge clk);
    chk("sh_write_we", 32'(mem_we), 1);
    reset = 1;
    #1;
    chk("rst_we_async", 32'(mem_we), 0);
    @(negedge clk);
    reset = 0;
    exp_rdata = 0;
    chk("rst_ready_after", 32'(ready), 1);
    chk("rst_rdata_after", rdata, 0);
    chk("rst_mem_kept", pm[4], 32'hDE55BEEF);
    for (int k = 0; k < 40; k++) xact(1'($urandom), 3'($urandom), $urandom, $urandom);
    mem_cmp();
    // req held high with alternating loads and stores
    acc = 0; dn = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          r = q.pop_front();
          model(r.w, r.f, r.a, r.d, el, ew, em);
          chk("s_mis", 32'(mis), 32'(em));
          chk("s_rdata", rdata, exp_rdata);
        end
      end
      req = c < 380;
      we = (acc % 2) == 1; f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (ready && req) begin
        q.push_back('{we, f3, addr, wdata});
        acc++;
      end
    end
    req = 0;
    chk("s_drain", 32'(q.size()), 0);
    chk("s_count", dn, acc);
    mem_cmp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
